dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data RAM between two requesters: the core load/store stage (port c_) and the program/data loader (port l_).
- Converts the core's byte, half and word accesses into RAM byte-lane enables and a word address.
- Handles the RAM's 1-cycle read latency and returns read data aligned and sign/zero-extended.
- Arbitration is core-priority, with a starvation guard for the loader.

Parameters:
ADDR_W, 14, RAM word-address width (byte address bits [ADDR_W+1:2] are used).
STARVE_LIMIT, 4, number of consecutive core grants while l_req is pending, after which the loader wins the next tie (1..15).

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
c_req  in  1  core request; payload held stable until c_gnt
c_we  in  1  1=store, 0=load
c_size  in  2  00=byte, 01=half, 10=word; 11 is treated as word
c_unsigned  in  1  load zero-extends when 1 (LBU/LHU)
c_addr  in  32  byte address
c_wdata  in  32  store data, LSB-justified
c_gnt  out  1  combinational 1-cycle accept pulse
c_err  out  1  registered 1-cycle pulse, cycle after a misaligned accept
c_rvalid  out  1  registered 1-cycle load-data-valid pulse
c_rdata  out  32  aligned, extended load data; valid with c_rvalid, held otherwise
l_req  in  1  loader request; word access only
l_we  in  1  1=write, 0=read
l_addr  in  32  byte address; bits [1:0] ignored
l_wdata  in  32  write word
l_gnt  out  1  combinational accept pulse
l_rvalid  out  1  registered read-valid pulse
l_rdata  out  32  read word
ram_we  out  4  byte-lane write enables
ram_re  out  4  byte-lane read enables
ram_addr  out  ADDR_W  word address
ram_wdata  out  32  lane-replicated write data
ram_rdata  in  32  RAM output, valid the cycle after ram_re

Behaviour:
- Reset: state IDLE, starve counter 0, all outputs 0 (c_rdata/l_rdata = 32'h0). A reset mid-read drops the transaction: no rvalid afterwards.
- FSM states:
  - IDLE: may grant.
  - RD_WAIT: RAM output pending; no grant.
  - RESP: drive rvalid; may grant, so back-to-back accesses are allowed.
- Transitions:
  - Granting a read → RD_WAIT.
  - Granting a write or a misaligned access → stay in, or go to, IDLE.
  - RD_WAIT → RESP unconditionally.
  - RESP with no read granted → IDLE.
- Arbitration (IDLE/RESP):
  - Only one requester active → that requester wins.
  - Both active → core wins, unless starve counter == STARVE_LIMIT, in which case the loader wins.
  - Counter increments (saturating) on each core grant while l_req=1.
  - Counter clears on a loader grant, or on any cycle with l_req=0.
- Grant cycle N: gnt, ram_* enables and ram_addr are driven combinationally in cycle N. The RAM sees exactly one access per grant.
- Lane rules (off = addr[1:0]):
  - byte: mask 0001<<off.
  - half: mask 0011<<off; off[0] must be 0.
  - word: mask 1111; off must be 00.
  - ram_wdata: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Misaligned core access (half with off[0]=1, or word with off≠0):
  - c_gnt still pulses; no ram_we/ram_re.
  - c_err pulses in N+1; no c_rvalid.
- Loader access: mask 1111; address = l_addr[ADDR_W+1:2].
- Read timing:
  - ram_rdata is valid in N+1 (RD_WAIT).
  - The block registers the extracted value; rvalid and rdata appear in N+2 (RESP).
  - Load-to-data latency is 2 cycles.
- Extraction:
  - byte = ram_rdata[8*off+:8], half = ram_rdata[16*off[1]+:16].
  - Sign-extend unless c_unsigned.
  - Word is passed through unchanged.
  - Offset, size and unsigned flag are registered at grant.
- A request deasserted before its grant has no effect. c_gnt and l_gnt are never high in the same cycle.

Test Plan:
- Core SW 0xDEADBEEF @0x10, then LW @0x10 → ram_we=1111, ram_addr=4; then c_rvalid exactly 2 cycles after c_gnt with c_rdata=0xDEADBEEF.
- SB 0x80 @0x13, then LB @0x13 and LBU @0x13 → ram_we=1000, ram_wdata=0x80808080; c_rdata=0xFFFFFF80 then 0x00000080.
- SH 0x8001 @0x16, then LH @0x16 → ram_we=1100; c_rdata=0xFFFF8001. LH @0x15 → c_gnt, no RAM enables, c_err pulse next cycle, no c_rvalid.
- c_req and l_req held high continuously with STARVE_LIMIT=4 → grant pattern C,C,C,C,L repeating; never both gnts in one cycle.
- Loader write of 0x12345678 @0x23 → ram_addr=8, ram_we=1111; a loader read of the same address returns l_rdata=0x12345678 with l_rvalid 2 cycles after l_gnt.
- rst asserted in the RD_WAIT cycle of a core load → all outputs 0 immediately; no c_rvalid after release; next request is granted from IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port, byte-lane data RAM between the core load/store
// stage (c_*) and the program/data loader (l_*).
//
// The core is favoured on a tie. A starvation counter lets the loader
// through once the core has won STARVE_LIMIT grants in a row while the
// loader was waiting.
//
// Core accesses of byte, half or word size become a lane mask and a word
// address. Misaligned core accesses are accepted, but they never reach
// the RAM and are reported on c_err instead.
//
// The RAM has a 1-cycle read latency. The extracted load value is
// registered, so rvalid/rdata appear two cycles after the grant.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   c_req/c_we/c_size/c_unsigned core request and payload
//   c_addr/c_wdata               core request and payload
//   c_gnt                        combinational accept pulse
//   c_err                        registered misalignment pulse
//   c_rvalid/c_rdata             aligned, extended load data
//   l_req/l_we/l_addr/l_wdata    loader word request
//   l_gnt                        combinational accept pulse
//   l_rvalid/l_rdata             loader read data
//   ram_we/ram_re                byte-lane enables
//   ram_addr                     RAM word address
//   ram_wdata                    lane-replicated write data
//   ram_rdata                    RAM read data
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [1:0]        c_size,
  input  logic              c_unsigned,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_err,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic [3:0]        ram_we,
  output logic [3:0]        ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  logic [1:0]  state_reg, state_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        rd_is_loader_reg;
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic        c_err_reg, c_rvalid_reg, l_rvalid_reg;
  logic [31:0] c_rdata_reg, l_rdata_reg;

  logic [1:0]  c_off;
  logic        c_is_byte, c_is_half, c_misaligned;
  logic [3:0]  c_mask;
  logic [31:0] c_wdata_rep;
  logic        can_grant, starve_hit, l_win, c_win, rd_start;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_ext;

  // Upper address bits beyond the RAM and the loader's byte offset are
  // intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[31:ADDR_W+2], l_addr[31:ADDR_W+2], l_addr[1:0]};

  // Core access decode; size 11 behaves as word.
  assign c_off        = c_addr[1:0];
  assign c_is_byte    = (c_size == 2'b00);
  assign c_is_half    = (c_size == 2'b01);
  assign c_misaligned = (c_is_half & c_off[0]) |
                        (~c_is_byte & ~c_is_half & (c_off != 2'b00));

  always_comb begin
    c_mask      = 4'b1111;
    c_wdata_rep = c_wdata;
    if (c_is_byte) begin
      c_mask      = 4'b0001 << c_off;
      c_wdata_rep = {4{c_wdata[7:0]}};
    end else if (c_is_half) begin
      c_mask      = 4'b0011 << c_off;
      c_wdata_rep = {2{c_wdata[15:0]}};
    end
  end

  // Arbitration. Reset gates the grants, so every output reads 0 while
  // rst is high, even with requests pending.
  assign can_grant  = ~rst & (state_reg != ST_RD_WAIT);
  assign starve_hit = (starve_cnt_reg == LIMIT);
  assign l_win      = can_grant & l_req & (~c_req | starve_hit);
  assign c_win      = can_grant & c_req & ~l_win;
  assign rd_start   = (l_win & ~l_we) | (c_win & ~c_misaligned & ~c_we);

  assign c_gnt = c_win;
  assign l_gnt = l_win;

  always_comb begin
    ram_we    = 4'b0000;
    ram_re    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (l_win) begin
      ram_addr  = l_addr[ADDR_W+1:2];
      ram_wdata = l_wdata;
      if (l_we) ram_we = 4'b1111;
      else      ram_re = 4'b1111;
    end else if (c_win) begin
      ram_addr  = c_addr[ADDR_W+1:2];
      ram_wdata = c_wdata_rep;
      // A misaligned access is accepted but kept off the RAM.
      if (!c_misaligned) begin
        if (c_we) ram_we = c_mask;
        else      ram_re = c_mask;
      end
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!l_req || l_win)
      starve_cnt_next = 4'd0;
    else if (c_win && starve_cnt_reg != 4'hF)
      starve_cnt_next = starve_cnt_reg + 4'd1;
  end

  always_comb begin
    state_next = ST_IDLE;
    if (rd_start)
      state_next = ST_RD_WAIT;
    else if (state_reg == ST_RD_WAIT)
      state_next = ST_RESP;
  end

  // Lane extraction uses the offset, size and signedness captured at grant.
  assign sel_byte = ram_rdata[{off_reg, 3'b000} +: 8];
  assign sel_half = ram_rdata[{off_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = ram_rdata;
    if (size_reg == 2'b00)
      load_ext = {{24{sel_byte[7] & ~uns_reg}}, sel_byte};
    else if (size_reg == 2'b01)
      load_ext = {{16{sel_half[15] & ~uns_reg}}, sel_half};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      starve_cnt_reg   <= 4'd0;
      rd_is_loader_reg <= 1'b0;
      off_reg          <= 2'b00;
      size_reg         <= 2'b00;
      uns_reg          <= 1'b0;
      c_err_reg        <= 1'b0;
      c_rvalid_reg     <= 1'b0;
      l_rvalid_reg     <= 1'b0;
      c_rdata_reg      <= 32'h0;
      l_rdata_reg      <= 32'h0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      c_err_reg      <= c_win & c_misaligned;
      c_rvalid_reg   <= (state_reg == ST_RD_WAIT) & ~rd_is_loader_reg;
      l_rvalid_reg   <= (state_reg == ST_RD_WAIT) & rd_is_loader_reg;
      if (rd_start) begin
        rd_is_loader_reg <= l_win;
        off_reg          <= c_off;
        size_reg         <= c_size;
        uns_reg          <= c_unsigned;
      end
      if (state_reg == ST_RD_WAIT) begin
        if (rd_is_loader_reg) l_rdata_reg <= ram_rdata;
        else                  c_rdata_reg <= load_ext;
      end
    end
  end

  assign c_err    = c_err_reg;
  assign c_rvalid = c_rvalid_reg;
  assign c_rdata  = c_rdata_reg;
  assign l_rvalid = l_rvalid_reg;
  assign l_rdata  = l_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a byte-lane RAM model that has
// a 1-cycle registered read.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0, c_unsigned = 1'b0;
  logic [1:0]  c_size = 2'b00;
  logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
  logic        c_gnt, c_err, c_rvalid;
  logic [31:0] c_rdata;
  logic        l_req = 1'b0, l_we = 1'b0;
  logic [31:0] l_addr = 32'h0, l_wdata = 32'h0;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic [3:0]  ram_we, ram_re;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [0:16383];

  dmem_arbiter #(.ADDR_W(14), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_unsigned(c_unsigned),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_err(c_err),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: byte-lane writes, registered read.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    if (|ram_re) ram_rdata <= mem[ram_addr];
  end

  // Present a core request at a negedge and settle the combinational outputs.
  task automatic core_issue(input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata);
    @(negedge clk);
    c_we = we; c_size = size; c_unsigned = uns; c_addr = addr; c_wdata = wdata;
    c_req = 1'b1;
    #1;
  endtask

  task automatic loader_issue(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
    @(negedge clk);
    l_we = we; l_addr = addr; l_wdata = wdata; l_req = 1'b1;
    #1;
  endtask

  // Let the grant edge pass, then withdraw all requests.
  task automatic release_reqs();
    @(posedge clk);
    #1;
    c_req = 1'b0;
    l_req = 1'b0;
  endtask

  task automatic test_reset();
    c_req = 1'b1;
    l_req = 1'b1;
    @(negedge clk);
    if ({c_gnt, l_gnt, c_err, c_rvalid, l_rvalid} !== 5'b0) begin
      $display("FAIL reset_flags: got %b want 00000", {c_gnt, l_gnt, c_err, c_rvalid, l_rvalid});
      n_fail++;
    end
    n_cmp++;
    if ({ram_we, ram_re, ram_addr, ram_wdata} !== 54'h0) begin
      $display("FAIL reset_ram: got %h want 0", {ram_we, ram_re, ram_addr, ram_wdata});
      n_fail++;
    end
    n_cmp++;
    if ({c_rdata, l_rdata} !== 64'h0) begin
      $display("FAIL reset_rdata: got %h want 0", {c_rdata, l_rdata});
      n_fail++;
    end
    n_cmp++;
    c_req = 1'b0;
    l_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_word();
    core_issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    if ({c_gnt, l_gnt, ram_we, ram_re} !== 10'b10_1111_0000) begin
      $display("FAIL sw_enables: got %b want 1011110000", {c_gnt, l_gnt, ram_we, ram_re});
      n_fail++;
    end
    n_cmp++;
    if (ram_addr !== 14'd4 || ram_wdata !== 32'hDEADBEEF) begin
      $display("FAIL sw_addr_data: got %0d/%h want 4/deadbeef", ram_addr, ram_wdata);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    core_issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    if ({c_gnt, ram_we, ram_re} !== 9'b1_0000_1111 || ram_addr !== 14'd4) begin
      $display("FAIL lw_enables: got %b/%0d want 100001111/4", {c_gnt, ram_we, ram_re}, ram_addr);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    @(negedge clk);
    if (c_rvalid !== 1'b0) begin
      $display("FAIL lw_rvalid_n1: got %b want 0", c_rvalid);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin
      $display("FAIL lw_data: got %b/%h want 1/deadbeef", c_rvalid, c_rdata);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin
      $display("FAIL lw_hold: got %b/%h want 0/deadbeef", c_rvalid, c_rdata);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_byte();
    core_issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080);
    if (ram_we !== 4'b1000 || ram_wdata !== 32'h80808080 || ram_addr !== 14'd4) begin
      $display("FAIL sb_lanes: got %b/%h/%0d want 1000/80808080/4", ram_we, ram_wdata, ram_addr);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    core_issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    if (ram_re !== 4'b1000) begin
      $display("FAIL lb_re: got %b want 1000", ram_re);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    @(negedge clk);
    @(negedge clk);
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hFFFFFF80) begin
      $display("FAIL lb_signed: got %b/%h want 1/ffffff80", c_rvalid, c_rdata);
      n_fail++;
    end
    n_cmp++;
    core_issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    release_reqs();
    @(negedge clk);
    @(negedge clk);
    if (c_rvalid !== 1'b1 || c_rdata !== 32'h00000080) begin
      $display("FAIL lbu_zero: got %b/%h want 1/00000080", c_rvalid, c_rdata);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_half();
    core_issue(1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001);
    if (ram_we !== 4'b1100 || ram_wdata !== 32'h80018001 || ram_addr !== 14'd5) begin
      $display("FAIL sh_lanes: got %b/%h/%0d want 1100/80018001/5", ram_we, ram_wdata, ram_addr);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    core_issue(1'b0, 2'b01, 1'b0, 32'h16, 32'h0);
    release_reqs();
    @(negedge clk);
    @(negedge clk);
    if (c_rvalid !== 1'b1 || c_rdata !== 32'hFFFF8001) begin
      $display("FAIL lh_signed: got %b/%h want 1/ffff8001", c_rvalid, c_rdata);
      n_fail++;
    end
    n_cmp++;
    // Misaligned half: accepted, never reaches the RAM, flagged next cycle.
    core_issue(1'b0, 2'b01, 1'b0, 32'h15, 32'h0);
    if ({c_gnt, ram_we, ram_re} !== 9'b1_0000_0000) begin
      $display("FAIL lh_mis_gnt: got %b want 100000000", {c_gnt, ram_we, ram_re});
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    @(negedge clk);
    if (c_err !== 1'b1 || c_rvalid !== 1'b0) begin
      $display("FAIL lh_mis_err: got err=%b rvalid=%b want 1/0", c_err, c_rvalid);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (c_err !== 1'b0 || c_rvalid !== 1'b0) begin
      $display("FAIL lh_mis_after: got err=%b rvalid=%b want 0/0", c_err, c_rvalid);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_starvation();
    int both_seen;
    both_seen = 0;
    @(negedge clk);
    c_we = 1'b1; c_size = 2'b10; c_addr = 32'h40; c_wdata = 32'h11111111;
    l_we = 1'b1; l_addr = 32'h80; l_wdata = 32'h22222222;
    c_req = 1'b1; l_req = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clk);
      if (c_gnt && l_gnt) both_seen++;
      if (c_gnt !== (k % 5 != 4) || l_gnt !== (k % 5 == 4)) begin
        $display("FAIL starve_cycle%0d: got c=%b l=%b want c=%b l=%b",
                 k, c_gnt, l_gnt, (k % 5 != 4), (k % 5 == 4));
        n_fail++;
      end
      n_cmp++;
    end
    if (both_seen !== 0) begin
      $display("FAIL starve_exclusive: got %0d overlapping cycles want 0", both_seen);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
  endtask

  task automatic test_loader();
    loader_issue(1'b1, 32'h23, 32'h12345678);
    if ({l_gnt, c_gnt, ram_we, ram_re} !== 10'b10_1111_0000 || ram_addr !== 14'd8
        || ram_wdata !== 32'h12345678) begin
      $display("FAIL ld_write: got %b/%0d/%h want 1011110000/8/12345678",
               {l_gnt, c_gnt, ram_we, ram_re}, ram_addr, ram_wdata);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    loader_issue(1'b0, 32'h20, 32'h0);
    if (l_gnt !== 1'b1 || ram_re !== 4'b1111 || ram_addr !== 14'd8) begin
      $display("FAIL ld_read_gnt: got %b/%b/%0d want 1/1111/8", l_gnt, ram_re, ram_addr);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
    @(negedge clk);
    if (l_rvalid !== 1'b0) begin
      $display("FAIL ld_rvalid_n1: got %b want 0", l_rvalid);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (l_rvalid !== 1'b1 || l_rdata !== 32'h12345678 || c_rvalid !== 1'b0) begin
      $display("FAIL ld_read_data: got %b/%h c_rvalid=%b want 1/12345678/0",
               l_rvalid, l_rdata, c_rvalid);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_read();
    core_issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    release_reqs();
    // Now in the RD_WAIT cycle.
    rst = 1'b1;
    #1;
    if ({c_rvalid, c_err, l_rvalid, c_rdata, l_rdata} !== 67'h0) begin
      $display("FAIL rst_mid_outputs: got %h want 0", {c_rvalid, c_err, l_rvalid, c_rdata, l_rdata});
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (c_rvalid !== 1'b0) begin
      $display("FAIL rst_mid_rvalid1: got %b want 0", c_rvalid);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin
      $display("FAIL rst_mid_rvalid2: got %b/%h want 0/0", c_rvalid, c_rdata);
      n_fail++;
    end
    n_cmp++;
    core_issue(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D);
    if (c_gnt !== 1'b1 || ram_we !== 4'b1111 || ram_addr !== 14'd12) begin
      $display("FAIL rst_regrant: got %b/%b/%0d want 1/1111/12", c_gnt, ram_we, ram_addr);
      n_fail++;
    end
    n_cmp++;
    release_reqs();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_starvation();
    test_loader();
    test_reset_mid_read();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
